// File: rtl/multicycle_controller.sv
// Multicycle control FSM (fetch / decode / execute-memory / writeback) for the 16-bit datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined instructions trap into FAULT instead of running as NOP.
module multicycle_controller #(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic [7:0]       psr,
  input  logic             memReady,
  output logic             irWrite,
  output logic             PCEN,
  output logic             PSREN,
  output logic             NextInstruction,
  output logic             StoreReg,
  output logic             WriteData,
  output logic             regWrite,
  output logic             ZeroExtend,
  output logic             SrcB,
  output logic             shiftType,
  output logic             JmpEN,
  output logic             BranchEN,
  output logic             JALEN,
  output logic             memWrite,
  output logic [3:0]       ALUcond,
  output logic [1:0]       chooseResult,
  output logic             memFault
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_RTYPE  = 4'd2,  S_ITYPE  = 4'd3,
    S_SHIFT  = 4'd4,  S_LDADDR = 4'd5,  S_LDWAIT = 4'd6,  S_STADDR = 4'd7,
    S_STWAIT = 4'd8,  S_BCOND  = 4'd9,  S_JCOND  = 4'd10, S_JAL    = 4'd11,
    S_NOP    = 4'd12, S_FAULT  = 4'd13
  } state_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam state_t S_ILLEGAL = S_FAULT;
`else
  localparam state_t S_ILLEGAL = S_NOP;
`endif

  localparam logic [3:0] TIMEOUT = 4'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             cond_q, cond_d;
  logic             settle_q;
  logic [3:0]       op_s, rdest_s, ext_s;
  logic             active_s;
  logic             unused_rsrc_s;

  function automatic logic cond_met(input logic [3:0] cc, input logic [7:0] flags);
    logic met;
    case (cc)
      4'b0000: met = flags[6];
      4'b0001: met = ~flags[6];
      4'b0010: met = flags[0];
      4'b0011: met = ~flags[0];
      4'b0110: met = flags[7];
      4'b0111: met = ~flags[7];
      4'b1110: met = 1'b1;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign op_s          = ir_q[15:12];
  assign rdest_s       = ir_q[11:8];
  assign ext_s         = ir_q[7:4];
  assign unused_rsrc_s = ^ir_q[3:0];
  // settle_q blanks every strobe in the first cycle after reset
  assign active_s      = ~reset & ~settle_q;

  // State register plus wait counter, latched instruction and sampled branch condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cnt_q    <= 4'd0;
      ir_q     <= {WIDTH{1'b0}};
      cond_q   <= 1'b0;
      settle_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      cond_q   <= cond_d;
      settle_q <= 1'b0;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    cond_d  = cond_q;
    if (settle_q) begin
      cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (memReady) begin
            ir_d    = instr;
            cnt_d   = 4'd0;
            state_d = S_DECODE;
          end else if (cnt_q == TIMEOUT) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_DECODE: begin
          cond_d = cond_met(rdest_s, psr);
          cnt_d  = 4'd0;
          case (op_s)
            4'b0000: state_d = S_RTYPE;
            4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b1001, 4'b1011, 4'b1101: state_d = S_ITYPE;
            4'b1000: state_d = S_SHIFT;
            4'b1100: state_d = S_BCOND;
            4'b0100: begin
              case (ext_s)
                4'b0000: state_d = S_LDADDR;
                4'b0100: state_d = S_STADDR;
                4'b1100: state_d = S_JCOND;
                4'b1000: state_d = S_JAL;
                default: state_d = S_ILLEGAL;
              endcase
            end
            default: state_d = S_ILLEGAL;
          endcase
        end
        S_LDADDR: state_d = S_LDWAIT;
        S_STADDR: state_d = S_STWAIT;
        S_LDWAIT, S_STWAIT: begin
          if (memReady) begin
            cnt_d   = 4'd0;
            state_d = S_FETCH;
          end else if (cnt_q == TIMEOUT) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        S_RTYPE, S_ITYPE, S_SHIFT, S_BCOND, S_JCOND, S_JAL, S_NOP: begin
          cnt_d   = 4'd0;
          state_d = S_FETCH;
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_FAULT;
      endcase
    end
  end

  // Control strobes decoded from the current state.
  always_comb begin
    irWrite         = 1'b0;
    PCEN            = 1'b0;
    PSREN           = 1'b0;
    NextInstruction = 1'b0;
    StoreReg        = 1'b0;
    WriteData       = 1'b0;
    regWrite        = 1'b0;
    ZeroExtend      = 1'b0;
    SrcB            = 1'b0;
    shiftType       = 1'b0;
    JmpEN           = 1'b0;
    BranchEN        = 1'b0;
    JALEN           = 1'b0;
    memWrite        = 1'b0;
    ALUcond         = 4'b0000;
    chooseResult    = 2'b00;
    memFault        = 1'b0;
    if (active_s) begin
      case (state_q)
        S_FETCH: begin
          NextInstruction = 1'b1;
          irWrite         = memReady;
        end
        S_RTYPE: begin
          ALUcond      = ext_s;
          SrcB         = 1'b1;
          chooseResult = 2'b01;
          PSREN        = 1'b1;
          PCEN         = 1'b1;
          regWrite     = (ext_s != 4'b1011);
          WriteData    = (ext_s != 4'b1011);
        end
        S_ITYPE: begin
          ALUcond      = op_s;
          ZeroExtend   = (op_s == 4'b0001) | (op_s == 4'b0010) | (op_s == 4'b0011);
          chooseResult = 2'b01;
          PSREN        = 1'b1;
          PCEN         = 1'b1;
          regWrite     = (op_s != 4'b1011);
          WriteData    = (op_s != 4'b1011);
        end
        S_SHIFT: begin
          shiftType = ir_q[4];
          regWrite  = 1'b1;
          WriteData = 1'b1;
          PCEN      = 1'b1;
        end
        // WriteData stays low so the register file takes memory data
        S_LDWAIT: begin
          regWrite = memReady;
          PCEN     = memReady;
        end
        S_STWAIT: begin
          memWrite = 1'b1;
          StoreReg = 1'b1;
          PCEN     = memReady;
        end
        S_BCOND: begin
          BranchEN     = cond_q;
          chooseResult = 2'b10;
          PCEN         = 1'b1;
        end
        S_JCOND: begin
          JmpEN        = cond_q;
          chooseResult = 2'b10;
          PCEN         = 1'b1;
        end
        S_JAL: begin
          JALEN        = 1'b1;
          chooseResult = 2'b11;
          regWrite     = 1'b1;
          WriteData    = 1'b1;
          PCEN         = 1'b1;
        end
        S_NOP:   PCEN = 1'b1;
        S_FAULT: memFault = 1'b1;
        default: memFault = 1'b0;
      endcase
    end else begin
      memFault = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus randomized instruction streams
// compared cycle by cycle against a per-instruction behavioural model.
module tb_multicycle_controller;

  logic        clk, reset, memReady;
  logic [15:0] instr;
  logic [7:0]  psr;
  logic        irWrite, PCEN, PSREN, NextInstruction, StoreReg, WriteData, regWrite;
  logic        ZeroExtend, SrcB, shiftType, JmpEN, BranchEN, JALEN, memWrite, memFault;
  logic [3:0]  ALUcond;
  logic [1:0]  chooseResult;

  typedef struct packed {
    logic irw, pcen, psren, nexti, storereg, writedata, regw, zext, srcb, shtype;
    logic jmp, br, jal, memw;
    logic [3:0] aluc;
    logic [1:0] chres;
    logic fault;
  } ctl_t;

  ctl_t obs;
  assign obs = {irWrite, PCEN, PSREN, NextInstruction, StoreReg, WriteData, regWrite, ZeroExtend,
                SrcB, shiftType, JmpEN, BranchEN, JALEN, memWrite, ALUcond, chooseResult, memFault};

  multicycle_controller #(.WIDTH(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr(instr), .psr(psr), .memReady(memReady),
    .irWrite(irWrite), .PCEN(PCEN), .PSREN(PSREN), .NextInstruction(NextInstruction),
    .StoreReg(StoreReg), .WriteData(WriteData), .regWrite(regWrite), .ZeroExtend(ZeroExtend),
    .SrcB(SrcB), .shiftType(shiftType), .JmpEN(JmpEN), .BranchEN(BranchEN), .JALEN(JALEN),
    .memWrite(memWrite), .ALUcond(ALUcond), .chooseResult(chooseResult), .memFault(memFault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int pcen_seen = 0;

  // Expected per-cycle script: inputs to drive and outputs to require.
  ctl_t        exp_q[$];
  ctl_t        msk_q[$];
  logic        rdy_q[$];
  logic [15:0] ins_q[$];
  logic [7:0]  psr_q[$];

  localparam int C_R = 0, C_I = 1, C_SH = 2, C_LD = 3, C_ST = 4, C_JC = 5, C_JAL = 6, C_BC = 7, C_ILL = 8;

  function automatic int classify(input logic [15:0] ins);
    logic [3:0] op, ext;
    op  = ins[15:12];
    ext = ins[7:4];
    if (op == 4'h0) return C_R;
    if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) return C_I;
    if (op == 4'h8) return C_SH;
    if (op == 4'hC) return C_BC;
    if (op == 4'h4 && ext == 4'h0) return C_LD;
    if (op == 4'h4 && ext == 4'h4) return C_ST;
    if (op == 4'h4 && ext == 4'hC) return C_JC;
    if (op == 4'h4 && ext == 4'h8) return C_JAL;
    return C_ILL;
  endfunction

  function automatic logic cond_true(input logic [3:0] cc, input logic [7:0] p);
    case (cc)
      4'h0: return p[6];
      4'h1: return !p[6];
      4'h2: return p[0];
      4'h3: return !p[0];
      4'h6: return p[7];
      4'h7: return !p[7];
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input ctl_t e, input ctl_t m, input logic rdy, input logic [15:0] ins, input logic [7:0] p);
    exp_q.push_back(e); msk_q.push_back(m); rdy_q.push_back(rdy); ins_q.push_back(ins); psr_q.push_back(p);
  endtask

  // Model of one instruction starting in FETCH: fw wait cycles before fetch completes, mw in LD/ST wait.
  task automatic build_instr(input logic [15:0] ins, input logic [7:0] p, input int fw, input int mw);
    ctl_t e, full, loose;
    logic [3:0] op, ext;
    int cls;
    full = '1; loose = '1; loose.writedata = 1'b0;
    op = ins[15:12]; ext = ins[7:4]; cls = classify(ins);
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.nexti = 1'b1; e.irw = (i == fw);
      push(e, full, (i == fw), ins, 8'($urandom));
    end
    e = '0;
    push(e, full, 1'($urandom), 16'($urandom), p);
    e = '0;
    case (cls)
      C_R: begin
        e.aluc = ext; e.srcb = 1'b1; e.chres = 2'b01; e.psren = 1'b1; e.pcen = 1'b1; e.regw = (ext != 4'hB);
        push(e, loose, 1'($urandom), 16'($urandom), 8'($urandom));
      end
      C_I: begin
        e.aluc = op; e.zext = (op >= 4'h1 && op <= 4'h3); e.chres = 2'b01; e.psren = 1'b1; e.pcen = 1'b1;
        e.regw = (op != 4'hB);
        push(e, loose, 1'($urandom), 16'($urandom), 8'($urandom));
      end
      C_SH: begin
        e.shtype = ins[4]; e.regw = 1'b1; e.pcen = 1'b1;
        push(e, loose, 1'($urandom), 16'($urandom), 8'($urandom));
      end
      C_LD, C_ST: begin
        push(e, full, 1'($urandom), 16'($urandom), 8'($urandom));
        e.memw = (cls == C_ST); e.storereg = (cls == C_ST);
        for (int i = 0; i < mw; i++) push(e, full, 1'b0, 16'($urandom), 8'($urandom));
        e.pcen = 1'b1; e.regw = (cls == C_LD);
        push(e, full, 1'b1, 16'($urandom), 8'($urandom));
      end
      C_BC, C_JC: begin
        e.br = (cls == C_BC) && cond_true(ins[11:8], p);
        e.jmp = (cls == C_JC) && cond_true(ins[11:8], p);
        e.chres = 2'b10; e.pcen = 1'b1;
        push(e, full, 1'($urandom), 16'($urandom), 8'($urandom));
      end
      C_JAL: begin
        e.jal = 1'b1; e.chres = 2'b11; e.regw = 1'b1; e.pcen = 1'b1;
        push(e, loose, 1'($urandom), 16'($urandom), 8'($urandom));
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        e.fault = 1'b1;
        push(e, full, 1'($urandom), 16'($urandom), 8'($urandom));
        push(e, full, 1'($urandom), 16'($urandom), 8'($urandom));
`else
        e.pcen = 1'b1;
        push(e, full, 1'($urandom), 16'($urandom), 8'($urandom));
`endif
      end
    endcase
  endtask

  task automatic run_script(input string name);
    ctl_t e, m;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      reset = 1'b0;
      memReady = rdy_q.pop_front(); instr = ins_q.pop_front(); psr = psr_q.pop_front();
      e = exp_q.pop_front(); m = msk_q.pop_front();
      @(negedge clk);
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s cycle %0d: strobes got %b required %b (mask %b)", name, cyc, obs, e, m);
      end
      if (obs.pcen === 1'b1) pcen_seen++;
      cyc++;
    end
  endtask

  task automatic do_reset(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; memReady = 1'($urandom); instr = 16'($urandom); psr = 8'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL %s during reset: got %b required 0", name, obs); end
    end
    @(posedge clk); #1;
    reset = 1'b0; memReady = 1'b1; instr = 16'h0152;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL %s cycle after reset: got %b required 0", name, obs); end
  endtask

  task automatic test_reset();
    ctl_t e;
    do_reset("reset", 3);
    @(posedge clk); #1;
    memReady = 1'b0;
    @(negedge clk);
    e = '0; e.nexti = 1'b1;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_fetch: got %b required %b", obs, e); end
  endtask

  task automatic test_alu();
    do_reset("alu_rst", 1);
    build_instr(16'h0152, 8'($urandom), 0, 0);
    build_instr(16'hB305, 8'($urandom), 0, 0);
    build_instr(16'h1305, 8'($urandom), 0, 0);
    build_instr(16'h8513, 8'($urandom), 1, 0);
    build_instr(16'h0B12, 8'($urandom), 0, 0);
    run_script("alu");
  endtask

  task automatic test_load_store();
    build_instr(16'h4103, 8'($urandom), 0, 3);
    build_instr(16'h4243, 8'($urandom), 0, 2);
    build_instr(16'h4103, 8'($urandom), 0, 0);
    run_script("load_store");
  endtask

  task automatic test_branch();
    build_instr(16'hC005, 8'h40, 0, 0);
    build_instr(16'hC005, 8'h00, 0, 0);
    build_instr(16'h43C1, 8'h00, 0, 0);
    build_instr(16'h43C1, 8'h01, 0, 0);
    build_instr(16'hCE00, 8'h00, 0, 0);
    build_instr(16'hC500, 8'hFF, 0, 0);
    build_instr(16'h4582, 8'($urandom), 0, 0);
    run_script("branch");
  endtask

  task automatic test_illegal();
    do_reset("illegal_rst", 1);
    build_instr(16'hF123, 8'($urandom), 0, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
    build_instr(16'h4333, 8'($urandom), 0, 0);
    build_instr(16'h0152, 8'($urandom), 0, 0);
`endif
    run_script("illegal");
  endtask

  task automatic test_boundary();
    do_reset("boundary_rst", 1);
    build_instr(16'h0152, 8'($urandom), 15, 0);
    build_instr(16'h4103, 8'($urandom), 0, 15);
    build_instr(16'h4243, 8'($urandom), 15, 15);
    run_script("boundary");
  endtask

  task automatic test_timeout();
    ctl_t e;
    do_reset("timeout_rst", 1);
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      memReady = (i < 16) ? 1'b0 : 1'($urandom); instr = 16'($urandom);
      @(negedge clk);
      e = '0;
      if (i < 16) e.nexti = 1'b1; else e.fault = 1'b1;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout cycle %0d: got %b required %b", i, obs, e); end
    end
    do_reset("timeout_clear", 1);
    build_instr(16'h0152, 8'($urandom), 0, 0);
    run_script("after_fault");
  endtask

  task automatic test_reset_in_store();
    ctl_t e[7];
    logic rs[7], rd[7];
    for (int i = 0; i < 7; i++) e[i] = '0;
    e[0].irw = 1'b1; e[0].nexti = 1'b1;
    e[3].memw = 1'b1; e[3].storereg = 1'b1;
    e[6].nexti = 1'b1;
    rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset("st_reset_rst", 1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      reset = rs[i]; memReady = rd[i]; instr = (i == 0) ? 16'h4243 : 16'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL reset_in_store cycle %0d: got %b required %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    int n, fw, mw;
    n = 40;
    do_reset("random_rst", 1);
    pcen_seen = 0;
    for (int k = 0; k < n; k++) begin
      ins = 16'($urandom);
      if (ins[15:12] == 4'h4 && $urandom_range(0, 3) != 0) ins[5:4] = 2'b00;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (classify(ins) == C_ILL) ins[15:12] = 4'h0;
`endif
      fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
      build_instr(ins, 8'($urandom), fw, mw);
    end
    run_script("random");
    checks++;
    if (pcen_seen != n) begin errors++; $display("FAIL random_pcen_count: got %0d required %0d", pcen_seen, n); end
  endtask

  initial begin
    reset = 1'b1; memReady = 1'b0; instr = 16'h0000; psr = 8'h00;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_illegal();
    test_boundary();
    test_timeout();
    test_reset_in_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit paired with the 16-bit datapath: consumes the fetched instruction and PSR flags and drives every datapath control strobe.
- Multicycle FSM: fetch, decode, execute/memory, writeback. One instruction retires per pass through FETCH.
- Handles memory wait states through a ready handshake and times out if memory never responds.
- Sits between instruction memory/data memory and the datapath. It is the producer of the control bundle that the datapath consumes.

Parameters:
- WIDTH, 16, instruction/data width.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for memReady before a fault is raised (4-bit wait counter).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr  input  WIDTH  instruction word from the memory bus (memdata), sampled in FETCH
- psr  input  8  PSR flags from datapath: bit0 C, bit2 L, bit5 F, bit6 Z, bit7 N
- memReady  input  1  memory completes current fetch/load/store this cycle
- irWrite  output  1  load instruction register
- PCEN, PSREN, NextInstruction, StoreReg, WriteData, regWrite, ZeroExtend, SrcB, shiftType, JmpEN, BranchEN, JALEN  output  1 each  datapath strobes
- memWrite  output  1  data-memory write request
- ALUcond  output  4  ALU operation select
- chooseResult  output  2  result select: 00 shifter, 01 ALU, 10 pcALU, 11 link
- memFault  output  1  sticky memory-timeout flag

Behaviour:
- Reset (synchronous, active-high, sampled on the clk rising edge):
  - State becomes FETCH, wait counter 0, memFault 0.
  - All strobes are 0 while reset is high and in the cycle after. Reset asserted mid-instruction abandons that instruction with no PCEN or regWrite.
- Decode fields: op = instr[15:12], rdest/cond = instr[11:8], ext = instr[7:4], rsrc = instr[3:0].
- FETCH:
  - NextInstruction = 1 and wait counter increments each cycle.
  - On memReady: irWrite = 1 for exactly that cycle, counter cleared, go to DECODE.
- DECODE: one cycle, no strobes. Next state by class:
  - op 0000: R-type.
  - op in {0001, 0010, 0011, 0101, 1001, 1011, 1101}: I-type.
  - op 1000: SHIFT.
  - op 0100: ext 0000 LOAD, ext 0100 STORE, ext 1100 JCOND, ext 1000 JAL.
  - op 1100: BCOND.
  - Anything else: NOP (PCEN only).
- R-type / I-type (one cycle, then FETCH):
  - ALUcond = ext for R-type, op for I-type.
  - SrcB = 1 for R-type, 0 for I-type.
  - ZeroExtend = 1 for I-type ops 0001/0010/0011.
  - chooseResult = 01, PSREN = 1, PCEN = 1.
  - regWrite = 1 except CMP (ALUcond 1011).
- SHIFT (one cycle): chooseResult = 00, shiftType = instr[4], regWrite = 1, PCEN = 1.
- LOAD:
  - LDWAIT holds NextInstruction = 0 until memReady.
  - On memReady: WriteData = 0 (memory data selected), regWrite = 1, PCEN = 1.
- STORE:
  - STWAIT holds memWrite = 1 and StoreReg = 1 until memReady.
  - On memReady: PCEN = 1. memWrite is never asserted outside STWAIT.
- Condition codes (evaluated on psr sampled in DECODE):
  - 0000 Z=1; 0001 Z=0; 0010 C=1; 0011 C=0; 0110 N=1; 0111 N=0; 1110 always.
  - All other codes: never.
- BCOND: BranchEN = condition, chooseResult = 10, PCEN = 1.
- JCOND: JmpEN = condition, chooseResult = 10, PCEN = 1.
- JAL: JALEN = 1, chooseResult = 11, regWrite = 1, PCEN = 1.
- Exactly one PCEN pulse per retired instruction.
- Latency with zero-wait memory: ALU/shift/branch/jump 3 cycles, load/store 4 cycles.
- Timeout:
  - The wait counter runs in FETCH, LDWAIT and STWAIT only, and saturates.
  - If it reaches MEM_TIMEOUT without memReady, go to FAULT: memFault = 1, all strobes 0, held until reset.
  - memReady in the same cycle the counter hits MEM_TIMEOUT counts as success.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN
  - Defined: an undefined op/ext in DECODE enters FAULT with memFault = 1. The instruction does not retire and PCEN is not pulsed.
  - Undefined: an undefined op/ext executes as NOP (PCEN pulse, no other strobes).

Test Plan:
- Reset then memReady = 1 every cycle, instr = 0x0152 (ADD R1,R2) -> irWrite at cycle 1; at cycle 3 regWrite = 1, PSREN = 1, ALUcond = 0101, SrcB = 1, chooseResult = 01, PCEN = 1.
- instr = 0xB305 (CMPI) -> regWrite = 0, PSREN = 1, ALUcond = 1011, SrcB = 0, PCEN = 1; instr = 0x1305 (ANDI) -> ZeroExtend = 1.
- instr = 0x4103 (LOAD), memReady low for 3 cycles in LDWAIT -> NextInstruction = 0 throughout; regWrite, WriteData = 0 and PCEN on the memReady cycle; 7 cycles total.
- instr = 0xC005 (BEQ) with psr[6] = 1 -> BranchEN = 1; repeat with psr[6] = 0 -> BranchEN = 0, PCEN = 1 in both.
- memReady held low in FETCH -> memFault = 1 after 15 cycles and strobes stay 0; assert reset -> memFault = 0 and FETCH resumes.
- reset asserted in STWAIT -> memWrite drops the next cycle, no PCEN, FETCH entered.
